// File: rtl/data_mem_pipe_pkg.sv
// Shared state encoding and default sizing for the data-memory pipeline.
package data_mem_pipe_pkg;

   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned DMEM_ADDR_W = 10;
   localparam int unsigned DMEM_DEPTH  = 64;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_BUSY = 2'd1,
      DMEM_RESP = 2'd2
   } dmem_state_e;

endpackage

// File: rtl/data_mem_pipe_dmem_array.sv
// DEPTH x DATA_W storage with per-byte write enables and a power-up image.
module dmem_array
   import data_mem_pipe_pkg::*;
#(
   parameter int unsigned DATA_W    = DMEM_DATA_W,
   parameter int unsigned DEPTH     = DMEM_DEPTH,
   parameter int unsigned INIT_MODE = 1,
   parameter int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clock,
   input  logic [IDX_W-1:0]    idx_i,
   input  logic                we_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] be_i,
   output logic [DATA_W-1:0]   rdata_o
);

   localparam int unsigned SLOTS = 2 ** IDX_W;

   logic [DATA_W-1:0] words [SLOTS];

   for (genvar i = 0; i < SLOTS; i++) begin : g_word
      if (i < DEPTH) begin : g_store
         // Power-up contents come from the declaration; no reset reaches the array.
         logic [DATA_W-1:0] word_q = (INIT_MODE == 1) ? DATA_W'(i) : '0;

         always_ff @(posedge clock) begin
            if (we_i && (idx_i == IDX_W'(i))) begin
               for (int unsigned k = 0; k < DATA_W / 8; k++) begin
                  if (be_i[k]) word_q[8*k +: 8] <= wdata_i[8*k +: 8];
               end
            end
         end

         assign words[i] = word_q;
      end else begin : g_pad
         assign words[i] = '0;
      end
   end

   assign rdata_o = words[idx_i];

endmodule

// File: rtl/data_mem_pipe.sv
// Single-port data memory with valid/ready request, configurable latency,
// byte-enable writes and address-error responses.
module data_mem_pipe
   import data_mem_pipe_pkg::*;
#(
   parameter int unsigned DATA_W    = DMEM_DATA_W,
   parameter int unsigned ADDR_W    = DMEM_ADDR_W,
   parameter int unsigned DEPTH     = DMEM_DEPTH,
   parameter int unsigned LATENCY   = 2,
   parameter int unsigned INIT_MODE = 1
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned OFF   = $clog2(BE_W);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(LATENCY + 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);

   dmem_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                eff_write;
   logic [ADDR_W-1:0]   eff_addr;
   logic [DATA_W-1:0]   eff_wdata;
   logic [BE_W-1:0]     eff_be;
   logic [ADDR_W:0]     word_ext;
   logic                addr_err;
   logic                enter_resp;
   logic                mem_we;
   logic [DATA_W-1:0]   mem_rdata;

   // With LATENCY==1 the commit edge is the accept edge, so the live request
   // feeds the array directly instead of the capture registers.
   always_comb begin
      eff_write = (state_q == DMEM_IDLE) ? req_write : wr_q;
      eff_addr  = (state_q == DMEM_IDLE) ? req_addr  : addr_q;
      eff_wdata = (state_q == DMEM_IDLE) ? req_wdata : wdata_q;
      eff_be    = (state_q == DMEM_IDLE) ? req_be    : be_q;
      word_ext  = {1'b0, eff_addr >> OFF};
      addr_err  = ((eff_addr & ALIGN_MASK) != '0) ||
                  (word_ext >= (ADDR_W + 1)'(DEPTH));
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      enter_resp = 1'b0;
      case (state_q)
         DMEM_IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d    = DMEM_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = DMEM_BUSY;
               end
            end
         end
         DMEM_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d    = DMEM_RESP;
               enter_resp = 1'b1;
            end
         end
         DMEM_RESP: state_d = DMEM_IDLE;
         default:   state_d = DMEM_IDLE;
      endcase
   end

   always_comb begin
      mem_we  = enter_resp && eff_write && !addr_err;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (enter_resp) begin
         err_d = addr_err;
         if (addr_err)       rdata_d = '0;
         else if (!eff_write) rdata_d = mem_rdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= DMEM_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   dmem_array #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .INIT_MODE (INIT_MODE),
      .IDX_W     (IDX_W)
   ) u_array (
      .clock   (clock),
      .idx_i   (word_ext[IDX_W-1:0]),
      .we_i    (mem_we),
      .wdata_i (eff_wdata),
      .be_i    (eff_be),
      .rdata_o (mem_rdata)
   );

   assign req_ready  = (state_q == DMEM_IDLE);
   assign resp_valid = (state_q == DMEM_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed scoreboard bench: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_data_mem_pipe;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int DP = 64;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic          req_valid = 1'b0, req_write = 1'b0;
   logic [AW-1:0] req_addr  = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [3:0]    req_be    = '0;
   logic          req_ready, resp_valid, resp_err;
   logic [DW-1:0] resp_rdata;

   logic          req_valid_1 = 1'b0, req_write_1 = 1'b0;
   logic [AW-1:0] req_addr_1  = '0;
   logic [DW-1:0] req_wdata_1 = '0;
   logic [3:0]    req_be_1    = '0;
   logic          req_ready_1, resp_valid_1, resp_err_1;
   logic [DW-1:0] resp_rdata_1;

   data_mem_pipe #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .LATENCY(2), .INIT_MODE(1)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   data_mem_pipe #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .LATENCY(1), .INIT_MODE(1)
   ) dut_l1 (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
      .req_addr(req_addr_1), .req_wdata(req_wdata_1), .req_be(req_be_1),
      .resp_valid(resp_valid_1), .resp_rdata(resp_rdata_1), .resp_err(resp_err_1)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [2][DP];
   logic [31:0] last  [2];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic get_ready(input int d);
      return (d == 0) ? req_ready : req_ready_1;
   endfunction

   function automatic logic get_valid(input int d);
      return (d == 0) ? resp_valid : resp_valid_1;
   endfunction

   task automatic drive(input int d, input logic v, input logic wr, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
      if (d == 0) begin
         req_valid = v; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
      end else begin
         req_valid_1 = v; req_write_1 = wr; req_addr_1 = a; req_wdata_1 = wd; req_be_1 = be;
      end
   endtask

   task automatic push_exp(input int d, input logic wr, input logic [AW-1:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
      exp_t          e;
      logic [AW-1:0] w;
      w     = a >> 2;
      e.lat = (d == 0) ? 2 : 1;
      e.err = (a[1:0] != 2'b00) || (w >= AW'(DP));
      if (e.err) begin
         e.rdata = '0;
      end else if (wr) begin
         for (int k = 0; k < 4; k++)
            if (be[k]) model[d][w[5:0]][8*k +: 8] = wd[8*k +: 8];
         e.rdata = last[d];
      end else begin
         e.rdata = model[d][w[5:0]];
      end
      sb.push_back(e);
   endtask

   task automatic await_resp(input int d);
      exp_t e;
      int   n   = 0;
      logic got = 1'b0;
      while (!got && n < 16) begin
         @(negedge clock);
         n++;
         got = get_valid(d);
      end
      e = sb.pop_front();
      check("resp_seen", 32'(got), 32'd1);
      check("latency", 32'(n), 32'(e.lat));
      if (got) begin
         check("rdata", (d == 0) ? resp_rdata : resp_rdata_1, e.rdata);
         check("err", 32'((d == 0) ? resp_err : resp_err_1), 32'(e.err));
         last[d] = e.rdata;
         @(negedge clock);
         check("pulse_width", 32'(get_valid(d)), 32'd0);
      end
   endtask

   task automatic issue(input int d, input logic wr, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
      @(negedge clock);
      check("ready_idle", 32'(get_ready(d)), 32'd1);
      drive(d, 1'b1, wr, a, wd, be);
      push_exp(d, wr, a, wd, be);
      @(posedge clock);
      #1;
      drive(d, 1'b0, 1'b0, '0, '0, '0);
      await_resp(d);
   endtask

   initial begin
      exp_t e;
      logic saw;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < DP; i++) model[d][i] = 32'(i);
         last[d] = '0;
      end

      repeat (2) @(negedge clock);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      reset_n = 1'b1;

      // Basic read, full-word write and byte-lane merging
      issue(0, 1'b0, 10'h010, '0, 4'h0);
      check("spec_read_0x010", last[0], 32'h0000_0004);
      issue(0, 1'b1, 10'h020, 32'hDEAD_BEEF, 4'hF);
      issue(0, 1'b0, 10'h020, '0, 4'h0);
      check("spec_raw_0x020", last[0], 32'hDEAD_BEEF);
      issue(0, 1'b1, 10'h024, 32'h0000_00AA, 4'h1);
      issue(0, 1'b1, 10'h024, 32'h0000_BB00, 4'h2);
      issue(0, 1'b0, 10'h024, '0, 4'h0);
      check("spec_merge_0x024", last[0], 32'h0000_BBAA);
      issue(0, 1'b1, 10'h028, 32'hFFFF_FFFF, 4'h0);
      issue(0, 1'b0, 10'h028, '0, 4'hF);

      // Address errors and no wrap-around write
      issue(0, 1'b0, 10'h102, '0, 4'h0);
      issue(0, 1'b1, 10'h100, 32'h5555_AAAA, 4'hF);
      issue(0, 1'b0, 10'h000, '0, 4'h0);
      check("spec_nowrap_0x000", last[0], 32'h0000_0000);
      issue(0, 1'b0, 10'h0FC, '0, 4'h0);

      // Reset while a write is in flight
      @(negedge clock);
      drive(0, 1'b1, 1'b1, 10'h030, 32'h1234_5678, 4'hF);
      @(posedge clock);
      #1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("midrst_ready", 32'(req_ready), 32'd1);
      check("midrst_rdata", resp_rdata, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      saw = 1'b0;
      repeat (4) begin
         @(negedge clock);
         saw = saw | resp_valid;
      end
      check("midrst_no_resp", 32'(saw), 32'd0);
      last[0] = '0;
      last[1] = '0;
      issue(0, 1'b0, 10'h030, '0, 4'h0);
      check("spec_abort_0x030", last[0], 32'h0000_000C);

      // req_valid held through BUSY/RESP
      @(negedge clock);
      drive(0, 1'b1, 1'b0, 10'h010, '0, 4'h0);
      push_exp(0, 1'b0, 10'h010, '0, 4'h0);
      check("hold_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      check("hold_busy_ready", 32'(req_ready), 32'd0);
      check("hold_busy_valid", 32'(resp_valid), 32'd0);
      @(negedge clock);
      check("hold_resp_ready", 32'(req_ready), 32'd0);
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      e = sb.pop_front();
      check("hold_rdata", resp_rdata, e.rdata);
      check("hold_err", 32'(resp_err), 32'(e.err));
      last[0] = e.rdata;
      drive(0, 1'b1, 1'b0, 10'h014, '0, 4'h0);
      push_exp(0, 1'b0, 10'h014, '0, 4'h0);
      @(negedge clock);
      check("hold_idle_ready", 32'(req_ready), 32'd1);
      check("hold_idle_valid", 32'(resp_valid), 32'd0);
      @(posedge clock);
      #1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      await_resp(0);
      check("hold_second_0x014", last[0], 32'h0000_0005);

      // LATENCY=1 instance
      issue(1, 1'b0, 10'h010, '0, 4'h0);
      check("l1_read_0x010", last[1], 32'h0000_0004);
      issue(1, 1'b1, 10'h040, 32'hCAFE_F00D, 4'hC);
      issue(1, 1'b0, 10'h040, '0, 4'h0);
      check("l1_merge_0x040", last[1], 32'hCAFE_0010);
      issue(1, 1'b0, 10'h041, '0, 4'h0);
      issue(1, 1'b1, 10'h3FC, 32'h1111_1111, 4'hF);
      issue(1, 1'b0, 10'h000, '0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
